// File: rtl/uart_receiver.sv
// UART receive stage: 2-FF synchronised rxd, start-bit validation and data sampling at mid-bit.
// Define RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_r_enable_i,
  input  logic                 rxd_i,
  input  logic                 rda_clear_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 rda_o,
  output logic                 framing_err_o,
  output logic                 overrun_o,
  output logic                 parity_err_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HalfTick = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FullTick = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LastBit  = BW'(DATA_BITS - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {Idle, Start, Data, Parity, Stop} state_e;
`else
  typedef enum logic [2:0] {Idle, Start, Data, Stop} state_e;
`endif

  state_e                 state_q, state_d;
  logic [1:0]             sync_q;
  logic [TW-1:0]          tickCnt_q, tickCnt_d;
  logic [BW-1:0]          bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   rda_q, rda_d;
  logic                   framingErr_q, framingErr_d;
  logic                   overrun_q, overrun_d;
  logic                   rxdSync;
  logic                   bitDone;
`ifdef RX_PARITY_EN
  logic                   parBit_q, parBit_d;
  logic                   parityErr_q, parityErr_d;
`endif

  assign rxdSync = sync_q[1];
  assign bitDone = baud_r_enable_i && (tickCnt_q == FullTick);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= Idle;
      sync_q       <= 2'b11;
      tickCnt_q    <= '0;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      rda_q        <= 1'b0;
      framingErr_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RX_PARITY_EN
      parBit_q     <= 1'b0;
      parityErr_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], rxd_i};
      tickCnt_q    <= tickCnt_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      rda_q        <= rda_d;
      framingErr_q <= framingErr_d;
      overrun_q    <= overrun_d;
`ifdef RX_PARITY_EN
      parBit_q     <= parBit_d;
      parityErr_q  <= parityErr_d;
`endif
    end
  end

  // Start bit is checked half a bit in; every later bit is sampled a full bit after the previous one.
  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    bitCnt_d  = bitCnt_q;
    if (baud_r_enable_i) begin
      unique case (state_q)
        Idle: begin
          if (!rxdSync) begin
            state_d   = Start;
            tickCnt_d = '0;
          end
        end
        Start: begin
          if (tickCnt_q == HalfTick) begin
            tickCnt_d = '0;
            if (!rxdSync) begin
              state_d  = Data;
              bitCnt_d = '0;
            end else begin
              state_d  = Idle;
            end
          end else begin
            tickCnt_d = tickCnt_q + TW'(1);
          end
        end
        Data: begin
          if (tickCnt_q == FullTick) begin
            tickCnt_d = '0;
            bitCnt_d  = bitCnt_q + BW'(1);
            if (bitCnt_q == LastBit) begin
`ifdef RX_PARITY_EN
              state_d = Parity;
`else
              state_d = Stop;
`endif
            end
          end else begin
            tickCnt_d = tickCnt_q + TW'(1);
          end
        end
`ifdef RX_PARITY_EN
        Parity: begin
          if (tickCnt_q == FullTick) begin
            tickCnt_d = '0;
            state_d   = Stop;
          end else begin
            tickCnt_d = tickCnt_q + TW'(1);
          end
        end
`endif
        Stop: begin
          if (tickCnt_q == FullTick) begin
            tickCnt_d = '0;
            state_d   = Idle;
          end else begin
            tickCnt_d = tickCnt_q + TW'(1);
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  // Frame completion takes priority over a simultaneous rda_clear.
  always_comb begin
    shift_d      = shift_q;
    data_d       = data_q;
    rda_d        = rda_q;
    framingErr_d = framingErr_q;
    overrun_d    = overrun_q;
`ifdef RX_PARITY_EN
    parBit_d     = parBit_q;
    parityErr_d  = parityErr_q;
    if (bitDone && state_q == Parity) parBit_d = rxdSync;
`endif
    if (bitDone && state_q == Data) shift_d = {rxdSync, shift_q[DATA_BITS-1:1]};
    if (bitDone && state_q == Stop) begin
      data_d       = shift_q;
      rda_d        = 1'b1;
      framingErr_d = ~rxdSync;
      overrun_d    = rda_q & ~rda_clear_i;
`ifdef RX_PARITY_EN
      parityErr_d  = (^shift_q) ^ parBit_q;
`endif
    end else if (rda_clear_i) begin
      rda_d        = 1'b0;
      framingErr_d = 1'b0;
      overrun_d    = 1'b0;
`ifdef RX_PARITY_EN
      parityErr_d  = 1'b0;
`endif
    end
  end

  assign data_o        = data_q;
  assign rda_o         = rda_q;
  assign framing_err_o = framingErr_q;
  assign overrun_o     = overrun_q;
`ifdef RX_PARITY_EN
  assign parity_err_o  = parityErr_q;
`else
  assign parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames, glitch, framing error, overrun, reset and parity.
// Honours RX_PARITY_EN the same way the design does.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud = 1'b0;
  logic       rxd = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       rda, framingErr, overrun, parityErr;
  int         errors = 0;
  int         checks = 0;

`ifdef RX_PARITY_EN
  localparam bit HasPar = 1'b1;
`else
  localparam bit HasPar = 1'b0;
`endif

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .baud_r_enable_i(baud),
    .rxd_i          (rxd),
    .rda_clear_i    (clr),
    .data_o         (data),
    .rda_o          (rda),
    .framing_err_o  (framingErr),
    .overrun_o      (overrun),
    .parity_err_o   (parityErr)
  );

  always #5 clk = ~clk;

  // Every comparison is counted here; mismatches print one line each.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One baud tick every fourth clock, optionally with rda_clear in the tick cycle.
  task automatic applyTick(input logic clear);
    baud = 1'b0;
    repeat (3) step();
    baud = 1'b1;
    clr  = clear;
    step();
    baud = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic sendBit(input logic b, input int n);
    rxd = b;
    repeat (n) applyTick(1'b0);
  endtask

  // The ninth stop-bit tick is the mid-stop sample where the frame completes.
  task automatic applyStimulus(input logic [7:0] value, input logic stopBit, input logic parBit,
                               input logic clearAtEnd, input int idleTicks);
    logic [7:0] v;
    v = value;
    sendBit(1'b0, 16);
    for (int i = 0; i < 8; i++) sendBit(v[i], 16);
    if (HasPar) sendBit(parBit, 16);
    rxd = stopBit;
    repeat (8) applyTick(1'b0);
    applyTick(clearAtEnd);
    repeat (7) applyTick(1'b0);
    rxd = 1'b1;
    repeat (idleTicks) applyTick(1'b0);
  endtask

  task automatic pulseClear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    checkOutput("reset data", 32'(data), 32'h0);
    checkOutput("reset rda", 32'(rda), 32'h0);
    checkOutput("reset framing", 32'(framingErr), 32'h0);
    checkOutput("reset overrun", 32'(overrun), 32'h0);
    checkOutput("reset parity", 32'(parityErr), 32'h0);
    rst_n = 1'b1;
    repeat (10) applyTick(1'b0);

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 20);
    checkOutput("A5 data", 32'(data), 32'hA5);
    checkOutput("A5 rda", 32'(rda), 32'h1);
    checkOutput("A5 framing", 32'(framingErr), 32'h0);
    checkOutput("A5 overrun", 32'(overrun), 32'h0);
    pulseClear();
    checkOutput("clear rda", 32'(rda), 32'h0);
    checkOutput("clear data held", 32'(data), 32'hA5);

    sendBit(1'b0, 4);
    sendBit(1'b1, 24);
    checkOutput("glitch rda", 32'(rda), 32'h0);
    checkOutput("glitch data", 32'(data), 32'hA5);

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 30);
    checkOutput("3C data", 32'(data), 32'h3C);
    checkOutput("3C rda", 32'(rda), 32'h1);
    checkOutput("3C framing", 32'(framingErr), 32'h1);
    checkOutput("3C overrun", 32'(overrun), 32'h0);
    pulseClear();
    checkOutput("3C cleared framing", 32'(framingErr), 32'h0);

    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("11 data", 32'(data), 32'h11);
    checkOutput("11 overrun", 32'(overrun), 32'h0);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("22 data", 32'(data), 32'h22);
    checkOutput("22 rda", 32'(rda), 32'h1);
    checkOutput("22 overrun", 32'(overrun), 32'h1);
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b1, 10);
    checkOutput("33 data", 32'(data), 32'h33);
    checkOutput("33 rda wins clear", 32'(rda), 32'h1);
    checkOutput("33 overrun after clear", 32'(overrun), 32'h0);

    sendBit(1'b0, 16);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 16);
    sendBit(1'b1, 8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midframe reset data", 32'(data), 32'h0);
    checkOutput("midframe reset rda", 32'(rda), 32'h0);
    step();
    rst_n = 1'b1;
    rxd   = 1'b1;
    repeat (20) applyTick(1'b0);
    checkOutput("post reset rda", 32'(rda), 32'h0);
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 10);
    checkOutput("5A data", 32'(data), 32'h5A);
    checkOutput("5A rda", 32'(rda), 32'h1);
    checkOutput("5A framing", 32'(framingErr), 32'h0);
    checkOutput("5A overrun", 32'(overrun), 32'h0);
    pulseClear();

`ifdef RX_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 10);
    checkOutput("07 even parity data", 32'(data), 32'h07);
    checkOutput("07 good parity", 32'(parityErr), 32'h0);
    pulseClear();
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 10);
    checkOutput("07 bad parity", 32'(parityErr), 32'h1);
    checkOutput("07 bad parity rda", 32'(rda), 32'h1);
`else
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 10);
    checkOutput("07 data", 32'(data), 32'h07);
    checkOutput("07 no parity", 32'(parityErr), 32'h0);
    checkOutput("07 framing", 32'(framingErr), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
